// File: rtl/interface_hcsr04_n_pkg.sv
// Shared definitions for the HC-SR04 interface: FSM state codes and
// parameter-sizing helpers.
package interface_hcsr04_n_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL  = 4'd0,
    ST_PREPARA  = 4'd1,
    ST_ENVIA    = 4'd2,
    ST_ESPERA   = 4'd3,
    ST_MEDINDO  = 4'd4,
    ST_ARMAZENA = 4'd5,
    ST_FINAL    = 4'd6,
    ST_ERRO     = 4'd7
  } estado_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/interface_hcsr04_n_contador_bcd_n.sv
// DIGITS-digit BCD up-counter for the centimetre count. Holds at LIMIT and
// also exposes the saturated "count + 1" value used for rounding.
module contador_bcd_n
  import interface_hcsr04_n_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned LIMIT  = 400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [4*DIGITS-1:0]   o_count,
  output logic [4*DIGITS-1:0]   o_next,
  output logic                  o_sat
);

  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 32'd10);
      t = t / 32'd10;
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [4*DIGITS-1:0] LIMIT_BCD = to_bcd(LIMIT);

  logic [4*DIGITS-1:0] r_count;
  logic                w_sat;

  assign w_sat   = (r_count == LIMIT_BCD);
  assign o_sat   = w_sat;
  assign o_count = r_count;
  assign o_next  = w_sat ? r_count : bcd_inc(r_count);

  // Count register: clear wins over increment; never steps past LIMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= bcd_inc(r_count);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/interface_hcsr04_n.sv
// HC-SR04 interface: issues the trigger pulse, times the synchronised echo
// and reports the distance in BCD centimetres with timeout/overflow errors.
module interface_hcsr04_n
  import interface_hcsr04_n_pkg::*;
#(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned TRIG_CYCLES = 500,
  parameter int unsigned CM_CYCLES   = 2941,
  parameter int unsigned ROUND_MODE  = 1,
  parameter int unsigned ECHO_WAIT   = 1_000_000,
  parameter int unsigned MAX_CM      = 400
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                medir,
  input  logic                echo,
  output logic                trigger,
  output logic [4*DIGITS-1:0] medida,
  output logic                pronto,
  output logic                erro,
  output logic [3:0]          db_estado
);

  localparam int unsigned CNT_MAX = max3(CM_CYCLES, TRIG_CYCLES, ECHO_WAIT);
  localparam int          CNT_W   = $clog2(CNT_MAX + 32'd1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_WAIT - 32'd1);
  localparam logic [CNT_W-1:0] CM_LAST   = CNT_W'(CM_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CM_HALF   = CNT_W'(CM_CYCLES / 32'd2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam bit WAIT_EN  = (ECHO_WAIT != 32'd0);
  localparam bit ROUND_EN = (ROUND_MODE != 32'd0);

  estado_t             r_state;
  estado_t             w_next;
  logic                r_echo_m;
  logic                r_echo_s;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_cm_clr;
  logic                w_cm_inc;
  logic                w_load;
  logic [4*DIGITS-1:0] w_cm_count;
  logic [4*DIGITS-1:0] w_cm_next;
  logic                w_cm_sat;
  logic [4*DIGITS-1:0] w_medida_next;
  logic                r_trigger;
  logic                r_pronto;
  logic                r_erro;
  logic [4*DIGITS-1:0] r_medida;

  contador_bcd_n #(
    .DIGITS (DIGITS),
    .LIMIT  (MAX_CM)
  ) u_cm (
    .clk     (clock),
    .rst_n   (reset),
    .i_clr   (w_cm_clr),
    .i_inc   (w_cm_inc),
    .o_count (w_cm_count),
    .o_next  (w_cm_next),
    .o_sat   (w_cm_sat)
  );

  // r_cnt holds the sub-centimetre remainder on MEDINDO exit, so it drives rounding.
  assign w_medida_next = (ROUND_EN && (r_cnt >= CM_HALF)) ? w_cm_next : w_cm_count;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_INICIAL;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, cycle-counter and cm-counter control.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_cm_clr   = 1'b0;
    w_cm_inc   = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      ST_INICIAL: begin
        if (medir) w_next = ST_PREPARA;
        else       w_next = ST_INICIAL;
      end
      ST_PREPARA: begin
        w_cnt_next = '0;
        w_cm_clr   = 1'b1;
        w_next     = ST_ENVIA;
      end
      ST_ENVIA: begin
        if (r_cnt == TRIG_LAST) begin
          w_cnt_next = '0;
          w_next     = ST_ESPERA;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_ESPERA: begin
        // The cycle that sees echo_s rise is the first counted echo cycle.
        if (r_echo_s) begin
          w_cnt_next = CNT_ONE;
          w_next     = ST_MEDINDO;
        end else if (WAIT_EN && (r_cnt == ECHO_LAST)) begin
          w_next = ST_ERRO;
        end else if (WAIT_EN) begin
          w_cnt_next = r_cnt + CNT_ONE;
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      ST_MEDINDO: begin
        if (!r_echo_s) begin
          w_next = ST_ARMAZENA;
        end else if (r_cnt == CM_LAST) begin
          if (w_cm_sat) begin
            w_next = ST_ERRO;
          end else begin
            w_cnt_next = '0;
            w_cm_inc   = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_ARMAZENA: begin
        w_load = 1'b1;
        w_next = ST_FINAL;
      end
      ST_FINAL: w_next = ST_INICIAL;
      ST_ERRO:  w_next = ST_INICIAL;
      default:  w_next = ST_INICIAL;
    endcase
  end

  // Echo synchroniser and cycle counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_echo_m <= 1'b0;
      r_echo_s <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_echo_m <= echo;
      r_echo_s <= r_echo_m;
      r_cnt    <= w_cnt_next;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_trigger <= 1'b0;
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
      r_medida  <= '0;
    end else begin
      r_trigger <= (w_next == ST_ENVIA);
      r_pronto  <= (w_next == ST_FINAL) || (w_next == ST_ERRO);
      if (w_next == ST_ERRO) begin
        r_erro <= 1'b1;
      end else if (w_next == ST_PREPARA) begin
        r_erro <= 1'b0;
      end else begin
        r_erro <= r_erro;
      end
      if (w_load) begin
        r_medida <= w_medida_next;
      end else begin
        r_medida <= r_medida;
      end
    end
  end

  assign trigger   = r_trigger;
  assign pronto    = r_pronto;
  assign erro      = r_erro;
  assign medida    = r_medida;
  assign db_estado = r_state;

endmodule

// File: tb/tb_interface_hcsr04_n.sv
// Scoreboard bench for interface_hcsr04_n: a rounding 3-digit build and a
// truncating 4-digit build share medir/echo, with scaled-down timing.
module tb_interface_hcsr04_n;

  localparam int TRIG = 5;
  localparam int CM   = 11;
  localparam int WAIT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger_a, pronto_a, erro_a;
  logic [11:0] medida_a;
  logic [3:0]  db_estado_a;
  logic        trigger_b, pronto_b, erro_b;
  logic [15:0] medida_b;
  logic [3:0]  db_estado_b;

  typedef struct packed {
    logic [15:0] medida;
    logic        erro;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] last_a;
  logic [15:0] last_b;
  int          n_tests;
  int          n_fail;

  always #10 clk = ~clk;

  interface_hcsr04_n #(
    .DIGITS(3), .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .ROUND_MODE(1),
    .ECHO_WAIT(WAIT), .MAX_CM(400)
  ) dut_a (
    .clock(clk), .reset(reset), .medir(medir), .echo(echo),
    .trigger(trigger_a), .medida(medida_a), .pronto(pronto_a),
    .erro(erro_a), .db_estado(db_estado_a)
  );

  interface_hcsr04_n #(
    .DIGITS(4), .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .ROUND_MODE(0),
    .ECHO_WAIT(WAIT), .MAX_CM(9999)
  ) dut_b (
    .clock(clk), .reset(reset), .medir(medir), .echo(echo),
    .trigger(trigger_b), .medida(medida_b), .pronto(pronto_b),
    .erro(erro_b), .db_estado(db_estado_b)
  );

  function automatic logic [15:0] to_bcd16(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // n = number of rising edges at which echo is high; -1 = no echo (timeout)
  function automatic exp_t model(input int n, input int max_cm, input bit rnd,
                                 input logic [15:0] last);
    exp_t e;
    int cm, rem, v;
    if (n < 0) begin
      e.erro = 1'b1; e.medida = last;
    end else begin
      cm = n / CM; rem = n % CM;
      if (cm > max_cm) begin
        e.erro = 1'b1; e.medida = last;
      end else begin
        v = cm + ((rnd && rem >= CM / 2) ? 1 : 0);
        if (v > max_cm) v = max_cm;
        e.erro = 1'b0; e.medida = to_bcd16(v);
      end
    end
    return e;
  endfunction

  task automatic push_expect(input int n);
    exp_t ea, eb;
    ea = model(n, 400, 1'b1, last_a);
    eb = model(n, 9999, 1'b0, last_b);
    last_a = ea.medida;
    last_b = eb.medida;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  // Scoreboard: every pronto pulse pops and checks one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (pronto_a === 1'b1) begin
      n_tests++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL pronto_a_unexpected: got pronto=1, expected none");
      end else begin
        e = qa.pop_front();
        if ({4'h0, medida_a} !== e.medida || erro_a !== e.erro) begin
          n_fail++;
          $display("FAIL result_a: got medida=%h erro=%b, expected medida=%h erro=%b",
                   medida_a, erro_a, e.medida[11:0], e.erro);
        end
      end
    end
    if (pronto_b === 1'b1) begin
      n_tests++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL pronto_b_unexpected: got pronto=1, expected none");
      end else begin
        e = qb.pop_front();
        if (medida_b !== e.medida || erro_b !== e.erro) begin
          n_fail++;
          $display("FAIL result_b: got medida=%h erro=%b, expected medida=%h erro=%b",
                   medida_b, erro_b, e.medida, e.erro);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 800 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d/%0d results pending, expected 0", name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic run_meas(input int n, input bit mid_pulse, input string name);
    push_expect(n);
    @(negedge clk) medir = 1'b1;
    @(negedge clk) medir = 1'b0;
    repeat (20) @(negedge clk);
    echo = 1'b1;
    for (int i = 0; i < n; i++) begin
      medir = (mid_pulse && i == n / 2);
      @(negedge clk);
    end
    medir = 1'b0;
    echo  = 1'b0;
    wait_drain(name);
  endtask

  task automatic test_reset;
    reset = 1'b0; medir = 1'b0; echo = 1'b0;
    last_a = 16'h0; last_b = 16'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({trigger_a, pronto_a, erro_a, medida_a, db_estado_a} !== 19'h0 ||
        {trigger_b, pronto_b, erro_b, medida_b, db_estado_b} !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_state: got a=%b%b%b %h %h b=%b%b%b %h %h, expected all 0",
               trigger_a, pronto_a, erro_a, medida_a, db_estado_a,
               trigger_b, pronto_b, erro_b, medida_b, db_estado_b);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    run_meas(1100, 1'b0, "exact_100");
    run_meas(1104, 1'b0, "trunc_100");
    run_meas(1105, 1'b0, "half_round");
    run_meas(824,  1'b0, "round_75");
  endtask

  task automatic test_range;
    run_meas(550,  1'b0, "cm_50");
    run_meas(2200, 1'b0, "cm_200");
  endtask

  task automatic test_timeout;
    int t_rise, t_pr, width;
    t_rise = -1; t_pr = -1; width = 0;
    push_expect(-1);
    @(negedge clk) medir = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      medir = 1'b0;
      if (trigger_a === 1'b1) begin
        width++;
        if (t_rise < 0) t_rise = cyc;
      end
      if (pronto_a === 1'b1 && t_pr < 0) t_pr = cyc;
    end
    n_tests++;
    if (width != TRIG) begin
      n_fail++;
      $display("FAIL trigger_width: got %0d cycles, expected %0d", width, TRIG);
    end
    n_tests++;
    if (t_rise < 0 || t_pr - t_rise != TRIG + WAIT) begin
      n_fail++;
      $display("FAIL timeout_delay: got %0d cycles, expected %0d", t_pr - t_rise, TRIG + WAIT);
    end
    wait_drain("no_echo");
    n_tests++;
    if (erro_a !== 1'b1 || erro_b !== 1'b1) begin
      n_fail++;
      $display("FAIL erro_persist: got a=%b b=%b, expected 1 1", erro_a, erro_b);
    end
    run_meas(33, 1'b0, "recover");
  endtask

  task automatic test_overflow;
    run_meas(4405, 1'b0, "sat_400");
    run_meas(4411, 1'b0, "over_401");
    run_meas(4730, 1'b0, "over_430");
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    @(negedge clk) medir = 1'b1;
    @(negedge clk) medir = 1'b0;
    repeat (20) @(negedge clk);
    echo = 1'b1;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (db_estado_a === 4'd4) seen = 1;
    end
    repeat (30) @(negedge clk);
    n_tests++;
    if (seen == 0 || medida_a === 12'h0) begin
      n_fail++;
      $display("FAIL reach_medindo: got seen=%0d medida=%h, expected 1 and nonzero", seen, medida_a);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (db_estado_a !== 4'd0 || trigger_a !== 1'b0 || medida_a !== 12'h0 ||
        db_estado_b !== 4'd0 || medida_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got st=%h trig=%b medida=%h st_b=%h medida_b=%h, expected 0",
               db_estado_a, trigger_a, medida_a, db_estado_b, medida_b);
    end
    @(negedge clk);
    reset = 1'b1;
    echo  = 1'b0;
    last_a = 16'h0; last_b = 16'h0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_medir_ignored;
    int trig_cnt;
    trig_cnt = 0;
    run_meas(550, 1'b1, "medir_mid");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (trigger_a === 1'b1 || trigger_b === 1'b1) trig_cnt++;
    end
    n_tests++;
    if (trig_cnt != 0 || db_estado_a !== 4'd0) begin
      n_fail++;
      $display("FAIL medir_ignored: got %0d trigger cycles state=%h, expected 0 and 0",
               trig_cnt, db_estado_a);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset;
    test_basic;
    test_range;
    test_timeout;
    test_overflow;
    test_reset_mid;
    test_medir_ignored;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
